// File: rtl/r5p_bus_arb_if.sv
// Request/response bundle shared by the two r5p requester ports and the memory port.
// The arbiter takes requests on the slave modport and drives memory through the master modport.
interface r5p_bus_arb_if #(
    parameter int AW = 22,
    parameter int DW = 32,
    parameter int BW = DW/8
);
    logic          vld;
    logic          wen;
    logic [AW-1:0] adr;
    logic [BW-1:0] ben;
    logic [DW-1:0] wdt;
    logic [DW-1:0] rdt;
    logic          rvl;
    logic          rdy;

    modport slave  (input vld, wen, adr, ben, wdt, output rdt, rvl, rdy);
    modport master (output vld, wen, adr, ben, wdt, input rdt, rdy);
endinterface

// File: rtl/r5p_bus_arb.sv
// Two-requester (IF/LS) arbiter onto a single unified memory port, with grant lock,
// round-robin or fixed priority, and read-response routing after a fixed latency.
module r5p_bus_arb #(
    parameter int AW  = 22,
    parameter int DW  = 32,
    parameter int BW  = DW/8,
    parameter int LAT = 1,
    parameter int PRI = 0
) (
    input  logic                clk,
    input  logic                rst,
    r5p_bus_arb_if.slave        s0,
    r5p_bus_arb_if.slave        s1,
    r5p_bus_arb_if.master       m
);
    localparam bit RR = (PRI == 0);

    typedef enum logic {ST_FREE, ST_LOCK} state_t;

    state_t        state, state_nxt;
    logic          lock_id, lock_id_nxt;
    logic          ptr, ptr_nxt;
    logic          gnt;
    logic          m_vld_c;
    logic          xfer;
    logic          wen_c;
    logic [AW-1:0] adr_c;
    logic [BW-1:0] ben_c;
    logic [DW-1:0] wdt_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_FREE;
            lock_id <= 1'b0;
            ptr     <= 1'b0;
        end else begin
            state   <= state_nxt;
            lock_id <= lock_id_nxt;
            ptr     <= ptr_nxt;
        end
    end

    // A stalled request pins the grant until its handshake, so no switch happens mid-request.
    always_comb begin
        gnt         = 1'b1;
        state_nxt   = state;
        lock_id_nxt = lock_id;
        ptr_nxt     = ptr;
        if (state == ST_LOCK)          gnt = lock_id;
        else if (s0.vld && s1.vld)     gnt = RR ? ptr : 1'b0;
        else if (s0.vld)               gnt = 1'b0;
        m_vld_c = ~rst & (gnt ? s1.vld : s0.vld);
        xfer    = m_vld_c & m.rdy;
        case (state)
            ST_FREE: if (m_vld_c && !m.rdy) begin
                state_nxt   = ST_LOCK;
                lock_id_nxt = gnt;
            end
            ST_LOCK: if (xfer) state_nxt = ST_FREE;
            default: state_nxt = ST_FREE;
        endcase
        if (xfer && RR) ptr_nxt = ~gnt;
    end

    // Idle selects s1, so the request fields carry s1 values when nobody asks.
    assign wen_c = gnt ? s1.wen : s0.wen;
    assign adr_c = gnt ? s1.adr : s0.adr;
    assign ben_c = gnt ? s1.ben : s0.ben;
    assign wdt_c = gnt ? s1.wdt : s0.wdt;

    assign m.vld = m_vld_c;
    assign m.wen = wen_c;
    assign m.adr = adr_c;
    assign m.ben = ben_c;
    assign m.wdt = wdt_c;

    assign s0.rdy = ~rst & m.rdy & ~gnt;
    assign s1.rdy = ~rst & m.rdy &  gnt;
    assign s0.rdt = m.rdt;
    assign s1.rdt = m.rdt;

    generate
        if (LAT == 0) begin : g_lat0
            assign s0.rvl = xfer & ~wen_c & ~gnt;
            assign s1.rvl = xfer & ~wen_c &  gnt;
        end else begin : g_pipe
            logic [LAT-1:0] vld_p;
            logic [LAT-1:0] id_p;

            // Response pipe: one slot per cycle of memory latency; writes push empty slots.
            always_ff @(posedge clk) begin
                if (rst) begin
                    vld_p <= '0;
                end else begin
                    vld_p[0] <= xfer & ~wen_c;
                    for (int i = 1; i < LAT; i++) vld_p[i] <= vld_p[i-1];
                end
            end

            always_ff @(posedge clk) begin
                id_p[0] <= gnt;
                for (int i = 1; i < LAT; i++) id_p[i] <= id_p[i-1];
            end

            assign s0.rvl = ~rst & vld_p[LAT-1] & ~id_p[LAT-1];
            assign s1.rvl = ~rst & vld_p[LAT-1] &  id_p[LAT-1];
        end
    endgenerate
endmodule

// File: tb/tb_r5p_bus_arb.sv
// Directed bench: three arbiter instances (LAT1/RR, LAT3/RR, LAT2/fixed) share one stimulus
// stream; each check targets the instance whose configuration it exercises.
module tb_r5p_bus_arb;
    localparam int AW = 22;
    localparam int DW = 32;
    localparam int BW = DW/8;

    logic          clk = 1'b0;
    logic          rst;
    logic          s0_vld, s0_wen, s1_vld, s1_wen, m_rdy;
    logic [AW-1:0] s0_adr, s1_adr;
    logic [BW-1:0] s0_ben, s1_ben;
    logic [DW-1:0] s0_wdt, s1_wdt, m_rdt;

    logic [2:0]    o_m_vld, o_m_wen, o_s0_rdy, o_s1_rdy, o_s0_rvl, o_s1_rvl;
    logic [AW-1:0] o_m_adr [3];
    logic [DW-1:0] o_s0_rdt [3];
    logic [DW-1:0] o_s1_rdt [3];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    genvar k;
    generate
        for (k = 0; k < 3; k++) begin : g
            r5p_bus_arb_if #(.AW(AW), .DW(DW), .BW(BW)) s0_if ();
            r5p_bus_arb_if #(.AW(AW), .DW(DW), .BW(BW)) s1_if ();
            r5p_bus_arb_if #(.AW(AW), .DW(DW), .BW(BW)) m_if ();

            assign s0_if.vld = s0_vld;
            assign s0_if.wen = s0_wen;
            assign s0_if.adr = s0_adr;
            assign s0_if.ben = s0_ben;
            assign s0_if.wdt = s0_wdt;
            assign s1_if.vld = s1_vld;
            assign s1_if.wen = s1_wen;
            assign s1_if.adr = s1_adr;
            assign s1_if.ben = s1_ben;
            assign s1_if.wdt = s1_wdt;
            assign m_if.rdt  = m_rdt;
            assign m_if.rdy  = m_rdy;
            assign m_if.rvl  = 1'b0;

            r5p_bus_arb #(
                .AW(AW), .DW(DW), .BW(BW),
                .LAT((k == 0) ? 1 : (k == 1) ? 3 : 2),
                .PRI((k == 2) ? 1 : 0)
            ) dut (
                .clk(clk),
                .rst(rst),
                .s0(s0_if),
                .s1(s1_if),
                .m(m_if)
            );

            assign o_m_vld[k]  = m_if.vld;
            assign o_m_wen[k]  = m_if.wen;
            assign o_m_adr[k]  = m_if.adr;
            assign o_s0_rdy[k] = s0_if.rdy;
            assign o_s1_rdy[k] = s1_if.rdy;
            assign o_s0_rvl[k] = s0_if.rvl;
            assign o_s1_rvl[k] = s1_if.rvl;
            assign o_s0_rdt[k] = s0_if.rdt;
            assign o_s1_rdt[k] = s1_if.rdt;
        end
    endgenerate

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v0, input logic w0, input logic [AW-1:0] a0,
                         input logic v1, input logic w1, input logic [AW-1:0] a1,
                         input logic rdy);
        s0_vld = v0; s0_wen = w0; s0_adr = a0;
        s1_vld = v1; s1_wen = w1; s1_adr = a1;
        m_rdy  = rdy;
        #2;
    endtask

    task automatic chk_quiet(input string tag);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("%s_mvld%0d", tag, i), o_m_vld[i], 1'b0);
            chk($sformatf("%s_rdy0_%0d", tag, i), o_s0_rdy[i], 1'b0);
            chk($sformatf("%s_rdy1_%0d", tag, i), o_s1_rdy[i], 1'b0);
            chk($sformatf("%s_rvl0_%0d", tag, i), o_s0_rvl[i], 1'b0);
            chk($sformatf("%s_rvl1_%0d", tag, i), o_s1_rvl[i], 1'b0);
        end
    endtask

    initial begin
        logic [7:0] v0m, v1m, wm, r0m, r1m;
        logic [AW-1:0] adr_t [8];
        int cnt0, cnt1;

        s0_ben = '1; s1_ben = 4'h3; s0_wdt = 32'hAAAA0000; s1_wdt = 32'h5555FFFF;
        m_rdt  = 32'h12345678;

        // Reset: outputs quiet even with both requesting and memory ready.
        rst = 1'b1;
        drive(1, 0, 'h100, 1, 0, 'h200, 1);
        tick();
        chk_quiet("rst");
        tick();
        rst = 1'b0;

        // Single requester read, latency 1/3/2 on the three instances.
        drive(1, 0, 'h000100, 0, 0, 'h0, 1);
        chk("sr_mvld", o_m_vld[0], 1'b1);
        chk("sr_madr", o_m_adr[0], 22'h000100);
        chk("sr_rdy0", o_s0_rdy[0], 1'b1);
        chk("sr_rdy1", o_s1_rdy[0], 1'b0);
        tick();
        drive(0, 0, 'h0, 0, 0, 'h0, 1);
        chk("sr_rvl0_l1", o_s0_rvl[0], 1'b1);
        chk("sr_rdt0_l1", o_s0_rdt[0], 32'h12345678);
        chk("sr_rvl1_l1", o_s1_rvl[0], 1'b0);
        chk("sr_rvl0_l2e", o_s0_rvl[2], 1'b0);
        tick();
        drive(0, 0, 'h0, 0, 0, 'h0, 1);
        chk("sr_rvl0_l1z", o_s0_rvl[0], 1'b0);
        chk("sr_rvl0_l2", o_s0_rvl[2], 1'b1);
        chk("sr_rvl0_l3e", o_s0_rvl[1], 1'b0);
        tick();
        chk("sr_rvl0_l3", o_s0_rvl[1], 1'b1);
        tick();

        // Contention: round-robin alternates from s0 after reset; fixed priority keeps s0.
        rst = 1'b1;
        drive(0, 0, 'h0, 0, 0, 'h0, 1);
        tick();
        rst = 1'b0;
        cnt0 = 0; cnt1 = 0;
        for (int i = 0; i < 8; i++) begin
            drive(1, 0, 'h000100, 1, 0, 'h000200, 1);
            chk($sformatf("rr_rdy0_c%0d", i), o_s0_rdy[0], (i % 2) == 0);
            chk($sformatf("rr_rdy1_c%0d", i), o_s1_rdy[0], (i % 2) == 1);
            chk($sformatf("rr_madr_c%0d", i), o_m_adr[0], ((i % 2) == 0) ? 22'h100 : 22'h200);
            chk($sformatf("fp_rdy0_c%0d", i), o_s0_rdy[2], 1'b1);
            if (i >= 1) begin
                chk($sformatf("rr_rvl0_c%0d", i), o_s0_rvl[0], ((i - 1) % 2) == 0);
                chk($sformatf("rr_rvl1_c%0d", i), o_s1_rvl[0], ((i - 1) % 2) == 1);
            end
            cnt0 += int'(o_s0_rdy[0]);
            cnt1 += int'(o_s1_rdy[0]);
            tick();
        end
        chk("rr_cnt0", cnt0, 4);
        chk("rr_cnt1", cnt1, 4);
        drive(0, 0, 'h000100, 1, 0, 'h000200, 1);
        chk("fp_rdy1_after", o_s1_rdy[2], 1'b1);
        chk("fp_madr_after", o_m_adr[2], 22'h000200);
        tick();

        // Lock: stalled s1 write keeps the grant while s0 waits.
        drive(0, 0, 'h0, 1, 1, 'h200010, 0);
        chk("lk_madr_c0", o_m_adr[0], 22'h200010);
        chk("lk_mwen_c0", o_m_wen[0], 1'b1);
        chk("lk_rdy1_c0", o_s1_rdy[0], 1'b0);
        tick();
        for (int i = 1; i < 3; i++) begin
            drive(1, 0, 'h000300, 1, 1, 'h200010, 0);
            chk($sformatf("lk_madr_c%0d", i), o_m_adr[0], 22'h200010);
            chk($sformatf("lk_rdy0_c%0d", i), o_s0_rdy[0], 1'b0);
            chk($sformatf("lk_fp_madr_c%0d", i), o_m_adr[2], 22'h200010);
            tick();
        end
        drive(1, 0, 'h000300, 1, 1, 'h200010, 1);
        chk("lk_rdy1_c3", o_s1_rdy[0], 1'b1);
        chk("lk_rdy0_c3", o_s0_rdy[0], 1'b0);
        chk("lk_madr_c3", o_m_adr[0], 22'h200010);
        chk("lk_fp_rdy1_c3", o_s1_rdy[2], 1'b1);
        tick();
        drive(1, 0, 'h000300, 1, 0, 'h200020, 1);
        chk("lk_rdy0_c4", o_s0_rdy[0], 1'b1);
        chk("lk_rdy1_c4", o_s1_rdy[0], 1'b0);
        chk("lk_madr_c4", o_m_adr[0], 22'h000300);
        chk("lk_wr_norvl", o_s1_rvl[0], 1'b0);
        tick();
        drive(0, 0, 'h0, 1, 0, 'h200020, 1);
        chk("lk_rdy1_c5", o_s1_rdy[0], 1'b1);
        chk("lk_rvl0_c5", o_s0_rvl[0], 1'b1);
        tick();

        // Response routing at latency 3 with a trailing write.
        rst = 1'b1;
        drive(0, 0, 'h0, 0, 0, 'h0, 1);
        tick();
        rst = 1'b0;
        v0m = 8'b0000_0101; v1m = 8'b0000_1010; wm = 8'b0000_1000;
        r0m = 8'b0010_1000; r1m = 8'b0001_0000;
        adr_t[0] = 'h10; adr_t[1] = 'h20; adr_t[2] = 'h30; adr_t[3] = 'h40;
        for (int i = 4; i < 8; i++) adr_t[i] = '0;
        for (int c = 0; c < 8; c++) begin
            m_rdt = 32'hD0000000 + c;
            drive(v0m[c], wm[c], adr_t[c], v1m[c], wm[c], adr_t[c], 1);
            if (v0m[c] || v1m[c]) chk($sformatf("rt_madr_c%0d", c), o_m_adr[1], adr_t[c]);
            chk($sformatf("rt_rvl0_c%0d", c), o_s0_rvl[1], r0m[c]);
            chk($sformatf("rt_rvl1_c%0d", c), o_s1_rvl[1], r1m[c]);
            if (c == 4) chk("rt_rdt1_c4", o_s1_rdt[1], 32'hD0000004);
            tick();
        end

        // Reset mid-flight drops in-flight reads and returns the pointer to s0.
        m_rdt = 32'h12345678;
        drive(1, 0, 'h000100, 0, 0, 'h0, 1);
        chk("rf_rdy0_c0", o_s0_rdy[2], 1'b1);
        chk("rf_rdy0_rr", o_s0_rdy[0], 1'b1);
        tick();
        rst = 1'b1;
        drive(0, 0, 'h0, 1, 0, 'h000200, 1);
        chk_quiet("rf_rst");
        tick();
        rst = 1'b0;
        drive(0, 0, 'h0, 0, 0, 'h0, 1);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rf_c2_rvl0_%0d", i), o_s0_rvl[i], 1'b0);
            chk($sformatf("rf_c2_rvl1_%0d", i), o_s1_rvl[i], 1'b0);
        end
        tick();
        drive(1, 0, 'h000100, 1, 0, 'h000200, 1);
        for (int i = 0; i < 3; i++) chk($sformatf("rf_c3_rvl0_%0d", i), o_s0_rvl[i], 1'b0);
        chk("rf_ptr_rdy0", o_s0_rdy[0], 1'b1);
        chk("rf_ptr_rdy1", o_s1_rdy[0], 1'b0);
        tick();
        drive(0, 0, 'h0, 0, 0, 'h0, 1);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
